mem_write_checker: RTL and testbench
====================================

# mem_write_checker

Synthesizable self-check block on the pipelined core's data-memory write port. It watches the memory-stage store bus (mem write enable, ALU result address, write data). It logs every store into a small first-word-fall-through FIFO and decides pass/fail/timeout in hardware. A bench or FPGA status LED reads the verdict without parsing waveforms.

## Interface
- DEPTH, 8: log FIFO entries; power of two, ≥2
- PASS_ADDR, 32'd100: store address that signals success
- PASS_DATA, 32'd25: store data required at PASS_ADDR
- IGNORE_ADDR, 32'd96: address whose stores are legal intermediate writes
- TIMEOUT, 16'd100: cycles in RUN before the verdict becomes timeout
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- mem_write  in  1  store valid this cycle (memory stage)
- addr  in  32  store address (ALU result, memory stage)
- wdata  in  32  store data (memory stage)
- pop  in  1  consume current log head
- log_valid  out  1  FIFO non-empty
- log_addr  out  32  head entry address; 0 when empty
- log_data  out  32  head entry data; 0 when empty
- log_full  out  1  FIFO holds DEPTH entries
- overflow  out  1  sticky: a store was dropped because the FIFO was full
- done  out  1  verdict reached (state ≠ RUN)
- pass  out  1  state == PASS
- fail  out  1  state == FAIL or TIMEOUT
- timed_out  out  1  state == TIMEOUT
- cycles  out  16  cycles spent in RUN, frozen once done

## Operation
- FSM states: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal until reset.
- In RUN, on each clk edge, first matching rule wins:
  - mem_write && addr==PASS_ADDR && wdata==PASS_DATA → PASS
  - mem_write && addr!=IGNORE_ADDR → FAIL. This includes PASS_ADDR with wrong data.
  - cycles == TIMEOUT-1 → TIMEOUT
  - otherwise stay in RUN and cycles += 1
- A store on the timeout cycle is evaluated; it takes precedence over timeout.
- cycles does not increment on the edge that leaves RUN. It saturates at 16'hFFFF.
- Logging: a push is requested when mem_write && state==RUN. This includes the deciding store. Stores after done are not logged.
- A push succeeds if the FIFO is not full, or if it is full and pop && log_valid in the same cycle.
- Otherwise the store is dropped and overflow sets. overflow clears only on reset.
- Pop with an empty FIFO is ignored. Simultaneous push and pop keeps the count unchanged.
- Pointers are log2(DEPTH) bits plus one wrap bit. Full = same index with wrap bits differing. Empty = pointers equal.
- Address and data comparisons are full 32-bit equality. There is no masking.

## Timing
- Reset (reset==0, async): state=RUN, cycles=0, FIFO empty, overflow=0. All outputs are 0.
- Reset asserted mid-operation discards the verdict and log immediately, without waiting for a clock.
- Deassertion is sampled by the next rising edge.
- Verdict latency: a store presented in cycle N is reflected in pass/fail/done after edge N. It is visible throughout cycle N+1.
- Log latency: a store pushed at edge N appears on log_addr/log_data with log_valid=1 after edge N, if the FIFO was empty.
- log_addr/log_data are combinational from the head register (FWFT). A pop at edge N presents the next entry after that edge.
- TIMEOUT: with no stores from reset release, timed_out rises after edge TIMEOUT counted from the first active edge. At that point cycles reads TIMEOUT-1.

## Test plan
- Store (96, 7) then (100, 25) on consecutive cycles → pass=1, done=1 the cycle after the second store. Log holds (96,7),(100,25) in order. fail=0.
- Store (100, 24) → fail=1, timed_out=0. A later (100, 25) does not change the verdict and is not logged.
- No stores, TIMEOUT=100 → after 100 edges: done=1, fail=1, timed_out=1, cycles=99. Then cycles stays constant.
- DEPTH=8, nine stores to 96 with pop=0 → log_full=1 after 8; 9th dropped; overflow=1. Pop all: 8 entries out in order, then log_valid=0, log_addr=0.
- FIFO full, store to 96 with pop=1 same cycle → count stays 8, overflow stays 0, new entry at tail.
- Pull reset low mid-run with 3 logged entries and no clock edge → all outputs 0 immediately. Release reset; the next run behaves as from power-up.

Source files
------------

// File: rtl/mem_write_checker.sv
// Store-bus self-check: logs every data-memory store into a FWFT FIFO and
// latches a pass / fail / timeout verdict that a bench or status LED can read.
module mem_write_checker #(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] PASS_ADDR   = 32'd100,
  parameter logic [31:0] PASS_DATA   = 32'd25,
  parameter logic [31:0] IGNORE_ADDR = 32'd96,
  parameter logic [15:0] TIMEOUT     = 16'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        pop,
  output logic        log_valid,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_full,
  output logic        overflow,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timed_out,
  output logic [15:0] cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    st_run     = 2'd0,
    st_pass    = 2'd1,
    st_fail    = 2'd2,
    st_timeout = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] cycles_r;
  logic [15:0] cycles_s;

  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [31:0]   addr_mem_r [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic          overflow_r;

  logic          empty_s;
  logic          full_s;
  logic          push_req_s;
  logic          pop_ok_s;
  logic          push_ok_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;

  assign wr_idx_s   = wr_ptr_r[AW-1:0];
  assign rd_idx_s   = rd_ptr_r[AW-1:0];
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign full_s     = (wr_idx_s == rd_idx_s) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign push_req_s = mem_write && (state_r == st_run);
  assign pop_ok_s   = pop && !empty_s;
  // A full FIFO still accepts a store when the head leaves in the same cycle.
  assign push_ok_s  = push_req_s && (!full_s || pop_ok_s);

  // Verdict rules in priority order; cycles holds on the edge that leaves RUN.
  always_comb begin
    state_s  = state_r;
    cycles_s = cycles_r;
    case (state_r)
      st_run: begin
        if (mem_write && (addr == PASS_ADDR) && (wdata == PASS_DATA)) begin
          state_s = st_pass;
        end else if (mem_write && (addr != IGNORE_ADDR)) begin
          state_s = st_fail;
        end else if (cycles_r == (TIMEOUT - 16'd1)) begin
          state_s = st_timeout;
        end else if (cycles_r != 16'hFFFF) begin
          cycles_s = cycles_r + 16'd1;
        end else begin
          cycles_s = cycles_r;
        end
      end
      st_pass:    state_s = st_pass;
      st_fail:    state_s = st_fail;
      st_timeout: state_s = st_timeout;
      default:    state_s = st_run;
    endcase
  end

  // Verdict state and run-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= st_run;
      cycles_r <= 16'd0;
    end else begin
      state_r  <= state_s;
      cycles_r <= cycles_s;
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_req_s && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Log storage; contents are only observable through valid pointers.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      addr_mem_r[wr_idx_s] <= addr;
      data_mem_r[wr_idx_s] <= wdata;
    end
  end

  assign log_valid = !empty_s;
  assign log_addr  = empty_s ? 32'd0 : addr_mem_r[rd_idx_s];
  assign log_data  = empty_s ? 32'd0 : data_mem_r[rd_idx_s];
  assign log_full  = full_s;
  assign overflow  = overflow_r;
  assign done      = (state_r != st_run);
  assign pass      = (state_r == st_pass);
  assign fail      = (state_r == st_fail) || (state_r == st_timeout);
  assign timed_out = (state_r == st_timeout);
  assign cycles    = cycles_r;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed table-driven bench for mem_write_checker plus hand-written
// sequences for timeout, timeout precedence and asynchronous reset.
module tb_mem_write_checker;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        pop;
  logic        log_valid;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_full;
  logic        overflow;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timed_out;
  logic [15:0] cycles;

  int checks = 0;
  int failures = 0;

  mem_write_checker dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .addr(addr),
    .wdata(wdata), .pop(pop), .log_valid(log_valid), .log_addr(log_addr),
    .log_data(log_data), .log_full(log_full), .overflow(overflow),
    .done(done), .pass(pass), .fail(fail), .timed_out(timed_out),
    .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic        pop;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_full;
    logic        e_ovf;
    logic        e_done;
    logic        e_pass;
    logic        e_fail;
    logic        e_to;
    logic [15:0] e_cyc;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic p, input logic ev,
                     input logic [31:0] ea, input logic [31:0] ed, input logic ef,
                     input logic eo, input logic edn, input logic ep,
                     input logic efl, input logic et, input logic [15:0] ec);
    vec_t v;
    v.rst = rst; v.we = we; v.a = a; v.d = d; v.pop = p;
    v.e_valid = ev; v.e_addr = ea; v.e_data = ed; v.e_full = ef; v.e_ovf = eo;
    v.e_done = edn; v.e_pass = ep; v.e_fail = efl; v.e_to = et; v.e_cyc = ec;
    vq.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, log_valid}, 32'd0);
    chk({tag, "_addr"}, log_addr, 32'd0);
    chk({tag, "_data"}, log_data, 32'd0);
    chk({tag, "_full"}, {31'd0, log_full}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_fail"}, {31'd0, fail}, 32'd0);
    chk({tag, "_to"}, {31'd0, timed_out}, 32'd0);
    chk({tag, "_cycles"}, {16'd0, cycles}, 32'd0);
  endtask

  // Assert reset mid-cycle, check outputs, release at a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0; pop = 1'b0;
    #2;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic p);
    mem_write = we; addr = a; wdata = d; pop = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0; pop = 1'b0;

    // Scenario A: ignore store then pass store; log drains in order.
    add(1, 1, 96, 7, 0,   1, 96, 7, 0, 0,   0, 0, 0, 0, 1);
    add(0, 1, 100, 25, 0, 1, 96, 7, 0, 0,   1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1,    1, 100, 25, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1,    0, 0, 0, 0, 0,    1, 1, 0, 0, 1);
    add(0, 1, 100, 25, 0, 0, 0, 0, 0, 0,    1, 1, 0, 0, 1);
    // Scenario B: wrong data at pass address; later stores ignored.
    add(1, 1, 100, 24, 0, 1, 100, 24, 0, 0, 1, 0, 1, 0, 0);
    add(0, 1, 100, 25, 0, 1, 100, 24, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1,    0, 0, 0, 0, 0,    1, 0, 1, 0, 0);
    // Scenario B2: upper address bits differ from pass address.
    add(1, 0, 0, 0, 0,    0, 0, 0, 0, 0,    0, 0, 0, 0, 1);
    add(0, 1, 32'h1000_0064, 25, 0, 1, 32'h1000_0064, 25, 0, 0, 1, 0, 1, 0, 1);
    // Scenario C: nine stores, ninth dropped; then drain.
    for (int i = 1; i <= 9; i++)
      add(i == 1, 1, 96, i, 0, 1, 96, 1, i >= 8, i == 9, 0, 0, 0, 0, 16'(i));
    for (int j = 1; j <= 8; j++)
      add(0, 0, 0, 0, 1, j < 8, (j < 8) ? 32'd96 : 32'd0, (j < 8) ? 32'(j + 1) : 32'd0,
          0, 1, 0, 0, 0, 0, 16'(9 + j));
    // Scenario D: push and pop together while full.
    for (int i = 1; i <= 8; i++)
      add(i == 1, 1, 96, 16 + i, 0, 1, 96, 17, i == 8, 0, 0, 0, 0, 0, 16'(i));
    add(0, 1, 96, 100, 1, 1, 96, 18, 1, 0, 0, 0, 0, 0, 9);
    for (int j = 1; j <= 8; j++)
      add(0, 0, 0, 0, 1, j < 8, (j < 8) ? 32'd96 : 32'd0,
          (j <= 6) ? 32'(18 + j) : ((j == 7) ? 32'd100 : 32'd0),
          0, 0, 0, 0, 0, 0, 16'(9 + j));

    for (int k = 0; k < vq.size(); k++) begin
      if (vq[k].rst) apply_reset();
      else @(negedge clk);
      drive(vq[k].we, vq[k].a, vq[k].d, vq[k].pop);
      chk($sformatf("v%0d_valid", k), {31'd0, log_valid}, {31'd0, vq[k].e_valid});
      chk($sformatf("v%0d_addr", k), log_addr, vq[k].e_addr);
      chk($sformatf("v%0d_data", k), log_data, vq[k].e_data);
      chk($sformatf("v%0d_full", k), {31'd0, log_full}, {31'd0, vq[k].e_full});
      chk($sformatf("v%0d_ovf", k), {31'd0, overflow}, {31'd0, vq[k].e_ovf});
      chk($sformatf("v%0d_done", k), {31'd0, done}, {31'd0, vq[k].e_done});
      chk($sformatf("v%0d_pass", k), {31'd0, pass}, {31'd0, vq[k].e_pass});
      chk($sformatf("v%0d_fail", k), {31'd0, fail}, {31'd0, vq[k].e_fail});
      chk($sformatf("v%0d_to", k), {31'd0, timed_out}, {31'd0, vq[k].e_to});
      chk($sformatf("v%0d_cycles", k), {16'd0, cycles}, {16'd0, vq[k].e_cyc});
    end

    // Timeout with no stores: verdict after edge 100, cycles frozen at 99.
    apply_reset();
    for (int k = 1; k <= 99; k++) begin
      @(posedge clk); #1;
      chk("to_early_done", {31'd0, done}, 32'd0);
    end
    chk("to_cycles99_pre", {16'd0, cycles}, 32'd99);
    @(posedge clk); #1;
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_fail", {31'd0, fail}, 32'd1);
    chk("to_timed_out", {31'd0, timed_out}, 32'd1);
    chk("to_pass", {31'd0, pass}, 32'd0);
    chk("to_cycles", {16'd0, cycles}, 32'd99);
    repeat (5) @(posedge clk);
    #1;
    chk("to_cycles_frozen", {16'd0, cycles}, 32'd99);
    chk("to_still", {31'd0, timed_out}, 32'd1);

    // A store on the timeout cycle wins over the timeout.
    apply_reset();
    repeat (99) @(posedge clk);
    @(negedge clk);
    drive(1, 100, 25, 0);
    chk("prec_pass", {31'd0, pass}, 32'd1);
    chk("prec_to", {31'd0, timed_out}, 32'd0);
    chk("prec_cycles", {16'd0, cycles}, 32'd99);
    chk("prec_log", log_addr, 32'd100);

    // Asynchronous reset mid-run with three logged entries.
    apply_reset();
    drive(1, 96, 1, 0);
    @(negedge clk); drive(1, 96, 2, 0);
    @(negedge clk); drive(1, 96, 3, 0);
    chk("mid_valid_pre", {31'd0, log_valid}, 32'd1);
    mem_write = 1'b0;
    reset = 1'b0;
    #1;
    check_all_zero("mid");
    @(negedge clk);
    reset = 1'b1;
    drive(1, 96, 7, 0);
    chk("post_head", log_data, 32'd7);
    chk("post_cycles", {16'd0, cycles}, 32'd1);
    @(negedge clk); drive(1, 100, 25, 1);
    chk("post_pass", {31'd0, pass}, 32'd1);
    chk("post_head2", log_data, 32'd25);
    @(negedge clk); drive(0, 0, 0, 1);
    chk("post_empty", {31'd0, log_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
